// File: rtl/vertex_acc_collector.sv
// Receive side of the Vertex PE output: sums CHUNKS_PER_FV beats of one node
// into a vertex result and queues completed results for downstream.
module vertex_acc_collector #(
    parameter int FV_SIZE       = 16,
    parameter int MAX_NODE_ID   = 256,
    parameter int CHUNKS_PER_FV = 4,
    parameter int FIFO_DEPTH    = 4,
    localparam int NID_W = $clog2(MAX_NODE_ID),
    localparam int CNT_W = $clog2(CHUNKS_PER_FV) + 1,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pe_valid,
    input  logic [FV_SIZE-1:0] pe_data,
    input  logic [NID_W-1:0]   pe_node_id,
    output logic               pe_ready,
    output logic               out_valid,
    output logic [FV_SIZE-1:0] out_data,
    output logic [NID_W-1:0]   out_node_id,
    input  logic               out_ready,
    output logic [FCW-1:0]     fifo_count,
    output logic               node_err
);
    typedef enum logic {IDLE, ACC} state_t;

    state_t             state_q, state_d;
    logic [FV_SIZE-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NID_W-1:0]   node_q, node_d;
    logic               err_q, err_d;

    logic [FV_SIZE-1:0] data_mem [FIFO_DEPTH];
    logic [NID_W-1:0]   nid_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FCW-1:0]     count_q, count_d;

    logic               accept, push, pop;
    logic [FV_SIZE-1:0] push_data;
    logic [NID_W-1:0]   push_node;

    // pe_ready looks only at registered occupancy, so a same-cycle pop never frees a slot
    assign pe_ready  = (count_q != FCW'(FIFO_DEPTH));
    assign accept    = pe_valid && pe_ready;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        node_d    = node_q;
        err_d     = err_q;
        push      = 1'b0;
        push_data = '0;
        push_node = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (CHUNKS_PER_FV == 1) begin
                        push      = 1'b1;
                        push_data = pe_data;
                        push_node = pe_node_id;
                    end else begin
                        acc_d   = pe_data;
                        node_d  = pe_node_id;
                        cnt_d   = CNT_W'(1);
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    if (pe_node_id != node_q) begin
                        // Drop the orphaned partial and restart on the new node
                        err_d  = 1'b1;
                        acc_d  = pe_data;
                        node_d = pe_node_id;
                        cnt_d  = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(CHUNKS_PER_FV - 1)) begin
                        push      = 1'b1;
                        push_data = acc_q + pe_data;
                        push_node = node_q;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        acc_d = acc_q + pe_data;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q + FCW'(push) - FCW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            node_q   <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            node_q   <= node_d;
            err_q    <= err_d;
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            data_mem[wr_ptr_q] <= push_data;
            nid_mem[wr_ptr_q]  <= push_node;
        end
    end

    assign out_data    = out_valid ? data_mem[rd_ptr_q] : '0;
    assign out_node_id = out_valid ? nid_mem[rd_ptr_q]  : '0;
    assign fifo_count  = count_q;
    assign node_err    = err_q;
endmodule

// File: tb/tb_vertex_acc_collector.sv
// Scoreboard bench for vertex_acc_collector: expected results are queued as
// stimulus is driven and retired when the DUT hands a result downstream.
module tb_vertex_acc_collector;
    logic        clk = 1'b0;
    logic        reset;
    logic        pe_valid;
    logic [15:0] pe_data;
    logic [7:0]  pe_node_id;
    logic        pe_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_node_id;
    logic        out_ready;
    logic [2:0]  fifo_count;
    logic        node_err;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb[$];

    vertex_acc_collector dut (
        .clk(clk), .reset(reset),
        .pe_valid(pe_valid), .pe_data(pe_data), .pe_node_id(pe_node_id),
        .pe_ready(pe_ready),
        .out_valid(out_valid), .out_data(out_data), .out_node_id(out_node_id),
        .out_ready(out_ready), .fifo_count(fifo_count), .node_err(node_err)
    );

    always #5 clk = ~clk;

    // Retire one expected result per downstream handshake
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got data=%h node=%0d, none expected", out_data, out_node_id);
            end else begin
                logic [23:0] exp;
                exp = sb.pop_front();
                if ({out_data, out_node_id} !== exp) begin
                    errors++;
                    $display("FAIL out_result: got data=%h node=%0d, want data=%h node=%0d",
                             out_data, out_node_id, exp[23:8], exp[7:0]);
                end
            end
        end
    end

    task automatic beat(input logic [15:0] d, input logic [7:0] n);
        pe_valid = 1'b1; pe_data = d; pe_node_id = n;
        @(posedge clk); #1;
        pe_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((fifo_count != 0 || sb.size() != 0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (fifo_count != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: fifo_count=%0d pending=%0d, want 0 and 0", fifo_count, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; pe_valid = 1'b0; pe_data = '0; pe_node_id = '0;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        @(negedge clk);
        checks++;
        if ({pe_ready, out_valid, out_data, out_node_id, fifo_count, node_err} !== {1'b1, 1'b0, 16'h0, 8'h0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h node=%0d cnt=%0d err=%b, want 1 0 0000 0 0 0",
                     pe_ready, out_valid, out_data, out_node_id, fifo_count, node_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        sb.push_back({16'd10, 8'd5});
        beat(16'd1, 8'd5); beat(16'd2, 8'd5); beat(16'd3, 8'd5); beat(16'd4, 8'd5);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_node_id} !== {1'b1, 16'd10, 8'd5}) begin
            errors++;
            $display("FAIL basic_latency: got vld=%b data=%0d node=%0d, want 1 10 5", out_valid, out_data, out_node_id);
        end
        @(posedge clk); #1;
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL basic_pop: fifo_count=%0d, want 0", fifo_count);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        sb.push_back({16'h0002, 8'd7});
        beat(16'hFFFF, 8'd7); beat(16'h0001, 8'd7); beat(16'h0000, 8'd7); beat(16'h0002, 8'd7);
        wait_drain();
        checks++;
        if (node_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_err: node_err=%b, want 0", node_err);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            sb.push_back({16'd4, 8'(n)});
            for (int b = 0; b < 4; b++) beat(16'd1, 8'(n));
        end
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd4 || pe_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: fifo_count=%0d pe_ready=%b, want 4 0", fifo_count, pe_ready);
        end
        // Offer a beat that must be refused while full
        @(posedge clk); #1;
        pe_valid = 1'b1; pe_data = 16'd1; pe_node_id = 8'd9;
        repeat (2) @(posedge clk);
        #1 pe_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL bp_reject: fifo_count=%0d, want 4", fifo_count);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pe_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_same_cycle: pe_ready=%b during first pop, want 0", pe_ready);
        end
        @(negedge clk);
        checks++;
        if (pe_ready !== 1'b1 || fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL bp_after_pop: pe_ready=%b fifo_count=%0d, want 1 3", pe_ready, fifo_count);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_mismatch();
        out_ready = 1'b1;
        sb.push_back({16'd4, 8'd9});
        beat(16'd5, 8'd3); beat(16'd5, 8'd3);
        for (int b = 0; b < 4; b++) beat(16'd1, 8'd9);
        wait_drain();
        checks++;
        if (node_err !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_err: node_err=%b, want 1", node_err);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        beat(16'd1, 8'd2); beat(16'd1, 8'd2);
        do_reset();
        checks++;
        if (node_err !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: node_err=%b fifo_count=%0d, want 0 0", node_err, fifo_count);
        end
        sb.push_back({16'd8, 8'd2});
        for (int b = 0; b < 4; b++) beat(16'd2, 8'd2);
        wait_drain();
        checks++;
        if (node_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_err: node_err=%b, want 0", node_err);
        end
    endtask

    task automatic test_simul_push_pop();
        out_ready = 1'b0;
        sb.push_back({16'd4, 8'd1});
        for (int b = 0; b < 4; b++) beat(16'd1, 8'd1);
        sb.push_back({16'd8, 8'd6});
        for (int b = 0; b < 3; b++) beat(16'd2, 8'd6);
        pe_valid = 1'b1; pe_data = 16'd2; pe_node_id = 8'd6; out_ready = 1'b1;
        @(posedge clk); #1;
        pe_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({fifo_count, out_data, out_node_id} !== {3'd1, 16'd8, 8'd6}) begin
            errors++;
            $display("FAIL simul_push_pop: cnt=%0d data=%0d node=%0d, want 1 8 6", fifo_count, out_data, out_node_id);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        reset = 1'b1; pe_valid = 1'b0; pe_data = '0; pe_node_id = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_mismatch();
        test_reset_mid();
        test_simul_push_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
